// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if -- word-side handshake between the UART word receiver and
// its consumer.
//   word_data  : assembled word, high byte received first
//   word_valid : word_data holds an unconsumed word
//   word_ready : consumer takes the word when word_valid & word_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, an unconsumed word was overwritten
//   busy       : receiver FSM is not idle
// master = receiver side, slave = consumer side.
interface uart_word_rx_if #(
  parameter int WORD_W = 16
) ();
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    output word_data, word_valid, frame_err, overrun, busy,
    input  word_ready
  );

  modport slave (
    input  word_data, word_valid, frame_err, overrun, busy,
    output word_ready
  );
endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx -- 8N1 UART receiver that pairs consecutive good bytes into a
// 16-bit word (first byte -> word[15:8], second byte -> word[7:0]).
//   sysclk      : single clock, rising edge
//   reset       : synchronous, active-high
//   uart_txd_in : asynchronous serial line, idles high
//   bus         : word handshake and status pulses (uart_word_rx_if.master)
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to the middle of the start bit, rejects short glitches
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit, then back to IDLE in the same cycle
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int WORD_W       = 16
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          uart_txd_in,
  uart_word_rx_if.master bus
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic [TW-1:0]     timer;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic [7:0]        hi_byte;
  logic              byte_ptr;
  logic              line_s;
  logic [WORD_W-1:0] word_next;

  assign line_s    = sync_q[1];
  assign word_next = {hi_byte, shift_reg};

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state          <= IDLE;
      sync_q         <= 2'b11;
      timer          <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      hi_byte        <= '0;
      byte_ptr       <= 1'b0;
      bus.word_data  <= '0;
      bus.word_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], uart_txd_in};
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;

      // Accept; a word completing in this same cycle overrides it below.
      if (bus.word_valid && bus.word_ready)
        bus.word_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!line_s) begin
            state    <= START;
            timer    <= '0;
            bus.busy <= 1'b1;
          end
        end

        START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_idx <= '0;
            if (!line_s) begin
              state <= DATA;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == T_FULL) begin
            timer     <= '0;
            shift_reg <= {line_s, shift_reg[7:1]};
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (timer == T_FULL) begin
            timer    <= '0;
            bit_idx  <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (line_s) begin
              if (!byte_ptr) begin
                hi_byte  <= shift_reg;
                byte_ptr <= 1'b1;
              end else begin
                byte_ptr       <= 1'b0;
                bus.word_data  <= word_next;
                bus.word_valid <= 1'b1;
                if (bus.word_valid && !bus.word_ready)
                  bus.overrun <= 1'b1;
              end
            end else begin
              // Bad stop bit: drop this byte and any held high byte.
              bus.frame_err <= 1'b1;
              byte_ptr      <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx with a short bit period (16 clocks per bit).
// A frame driven from negedge k=0 is detected at edge 2, mid-start at edge
// 2+CLKS/2, data samples every CLKS after that, stop sample at edge
// 2+CLKS/2+9*CLKS-... = 154; word_valid is then seen at the following negedge.
module tb_uart_word_rx;
  localparam int CLKS = 16;
  localparam int LAT  = 2 + CLKS / 2 + 9 * CLKS + 1;  // start negedge -> valid seen

  logic sysclk      = 1'b0;
  logic reset       = 1'b1;
  logic uart_txd_in = 1'b1;

  uart_word_rx_if #(.WORD_W(16)) bus ();

  uart_word_rx #(
    .CLKS_PER_BIT(CLKS),
    .WORD_W      (16)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .uart_txd_in(uart_txd_in),
    .bus        (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_assert   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int fe_cnt     = 0;
  int ov_cnt     = 0;
  int rise_cnt   = 0;
  int t_rise     = 0;
  int last_start = 0;
  logic prev_valid = 1'b0;
  logic [15:0] acc_q[$];

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun) ov_cnt++;
    if (bus.word_valid && !prev_valid) begin
      rise_cnt++;
      t_rise = cyc;
    end
    prev_valid = bus.word_valid;
  end

  // Pre-edge values: the words actually handed over.
  always @(posedge sysclk)
    if (!reset && bus.word_valid && bus.word_ready) acc_q.push_back(bus.word_data);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge; word_ready is raised just
  // before edge ready_at (relative to the frame) when ready_at >= 0.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int ready_at);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    last_start = cyc;
    for (int k = 0; k < 10 * CLKS; k++) begin
      uart_txd_in = frame[k / CLKS];
      if (k == ready_at) bus.word_ready = 1'b1;
      @(negedge sysclk);
    end
  endtask

  task automatic idle(input int n);
    uart_txd_in = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    logic [9:0]  frame;
    logic [15:0] w;
    logic [15:0] exp_q[$];
    int fe0, ov0, rise0;

    bus.word_ready = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_data", 32'(bus.word_data), 32'h0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    idle(4);

    // Basic word, latency and hold-until-ready
    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'hC3, 1'b1, -1);
    check("basic_latency", 32'(t_rise - last_start), 32'(LAT));
    check("basic_data", 32'(bus.word_data), 32'hA5C3);
    check("basic_valid_held", 32'(bus.word_valid), 32'd1);
    check("basic_ferr_cnt", 32'(fe_cnt), 32'd0);
    bus.word_ready = 1'b1;
    @(negedge sysclk);
    bus.word_ready = 1'b0;
    check("basic_accept_clr", 32'(bus.word_valid), 32'd0);

    // Short low glitch on the line
    fe0 = fe_cnt; rise0 = rise_cnt;
    uart_txd_in = 1'b0;
    repeat (CLKS / 4) @(negedge sysclk);
    check("glitch_busy_hi", 32'(bus.busy), 32'd1);
    idle(2 * CLKS);
    check("glitch_busy_lo", 32'(bus.busy), 32'd0);
    check("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_no_word", 32'(rise_cnt - rise0), 32'd0);

    // Bad stop bit, then a clean word
    fe0 = fe_cnt;
    send_byte(8'h12, 1'b0, -1);
    idle(2 * CLKS);
    send_byte(8'h34, 1'b1, -1);
    send_byte(8'h56, 1'b1, -1);
    check("ferr_pulse_cnt", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_data", 32'(bus.word_data), 32'h3456);
    check("ferr_valid", 32'(bus.word_valid), 32'd1);
    bus.word_ready = 1'b1;
    @(negedge sysclk);
    bus.word_ready = 1'b0;

    // Overrun
    ov0 = ov_cnt;
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    check("ovr_pulse_cnt", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_data", 32'(bus.word_data), 32'h2222);
    check("ovr_valid", 32'(bus.word_valid), 32'd1);
    bus.word_ready = 1'b1;
    @(negedge sysclk);
    bus.word_ready = 1'b0;
    check("ovr_accept_clr", 32'(bus.word_valid), 32'd0);

    // Accept in the same cycle as the next completion
    acc_q.delete();
    ov0 = ov_cnt;
    send_byte(8'h12, 1'b1, -1);
    send_byte(8'h34, 1'b1, -1);
    send_byte(8'hBE, 1'b1, -1);
    send_byte(8'hEF, 1'b1, LAT - 1);
    idle(4);
    bus.word_ready = 1'b0;
    check("same_cyc_count", 32'(acc_q.size()), 32'd2);
    check("same_cyc_old", 32'((acc_q.size() > 0) ? acc_q[0] : 16'hxxxx), 32'h1234);
    check("same_cyc_new", 32'((acc_q.size() > 1) ? acc_q[1] : 16'hxxxx), 32'hBEEF);
    check("same_cyc_no_ovr", 32'(ov_cnt - ov0), 32'd0);

    // Reset during data bit 3 of a frame, with a pending word and a held
    // high byte. The frame tail (data low, stop low, line held low a little
    // longer) is seen as a new start and ends in a frame error.
    send_byte(8'h5A, 1'b1, -1);
    send_byte(8'h5A, 1'b1, -1);
    send_byte(8'h99, 1'b1, -1);
    fe0 = fe_cnt; rise0 = rise_cnt;
    frame = {1'b0, 8'h0F, 1'b0};
    for (int k = 0; k < 236; k++) begin
      if (k == 70) reset = 1'b1;
      if (k == 72) reset = 1'b0;
      if (k == 71) begin
        check("midrst_valid", 32'(bus.word_valid), 32'd0);
        check("midrst_data", 32'(bus.word_data), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ferr", 32'(bus.frame_err), 32'd0);
        check("midrst_ovr", 32'(bus.overrun), 32'd0);
      end
      uart_txd_in = (k < 10 * CLKS) ? frame[k / CLKS] : 1'b0;
      @(negedge sysclk);
    end
    idle(2 * CLKS);
    check("midrst_tail_ferr_le1", 32'((fe_cnt - fe0) <= 1), 32'd1);
    check("midrst_tail_no_word", 32'(rise_cnt - rise0), 32'd0);
    send_byte(8'hCA, 1'b1, -1);
    send_byte(8'hFE, 1'b1, -1);
    check("midrst_next_data", 32'(bus.word_data), 32'hCAFE);
    check("midrst_next_valid", 32'(bus.word_valid), 32'd1);
    bus.word_ready = 1'b1;
    @(negedge sysclk);

    // 17 back-to-back words with word_ready held high
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) begin
      w = 16'(16'hA001 + i * 16'h0913);
      exp_q.push_back(w);
      send_byte(w[15:8], 1'b1, -1);
      send_byte(w[7:0], 1'b1, -1);
    end
    idle(4);
    check("b2b_count", 32'(acc_q.size()), 32'd17);
    for (int i = 0; i < 17; i++)
      check($sformatf("b2b_word%0d", i),
            32'((i < acc_q.size()) ? acc_q[i] : 16'hxxxx), 32'(exp_q[i]));
    check("b2b_no_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("b2b_no_ovr", 32'(ov_cnt - ov0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
